// File: rtl/cg_bank_arbiter.sv
// Two-requester round-robin arbiter owning a 16-bit nibble-masked register bank with clock-gate enables.
// Latency: one IDLE cycle before ready; accepted beat visible on out and cg_en one cycle later.
// Backpressure: ready is a pure function of ownership; non-owner stalls until the burst ends via last or MAX_BURST.
module cg_bank_arbiter #(
    parameter int FORCE_MERGE = 1,  // 1: one shared enable for all nibbles, 0: per-nibble enables
    parameter int MAX_BURST   = 8   // beats per ownership before forced release, 2..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic        a_last,
    input  logic [3:0]  a_mask,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic        b_last,
    input  logic [3:0]  b_mask,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic [15:0] out,
    output logic [3:0]  cg_en,
    output logic [1:0]  owner
);

    // State encoding doubles as the owner output, so 2'b11 is unreachable.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic [3:0] MAX_B = MAX_BURST[3:0];

    state_t      state_q, state_d;
    logic        rr_q, rr_d;        // 0: A wins a tie, 1: B wins a tie
    logic [3:0]  cnt_q, cnt_d;      // beats accepted in the current burst
    logic [15:0] out_q, out_d;
    logic [3:0]  cg_en_q, cg_en_d;

    // Beat selected from the current owner, shared by the datapath below.
    logic        beat_acc;
    logic [3:0]  beat_mask;
    logic [15:0] beat_data;
    logic [3:0]  cnt_inc;
    logic [3:0]  gate;

    assign cnt_inc = cnt_q + 4'd1;

    // Next-state, ready generation and owner beat selection.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        beat_acc  = 1'b0;
        beat_mask = 4'h0;
        beat_data = 16'h0000;
        case (state_q)
            IDLE: begin
                // Grant costs one cycle; on a tie the rr pointer decides.
                if (a_valid && (!b_valid || !rr_q)) begin
                    state_d = OWN_A;
                    cnt_d   = 4'd0;
                end else if (b_valid) begin
                    state_d = OWN_B;
                    cnt_d   = 4'd0;
                end
            end
            OWN_A: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    beat_acc  = 1'b1;
                    beat_mask = a_mask;
                    beat_data = a_data;
                    cnt_d     = cnt_inc;
                    // Forced release at MAX_BURST behaves exactly like last.
                    if (a_last || (cnt_inc == MAX_B)) begin
                        state_d = IDLE;
                        rr_d    = 1'b1;
                    end
                end
            end
            OWN_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    beat_acc  = 1'b1;
                    beat_mask = b_mask;
                    beat_data = b_data;
                    cnt_d     = cnt_inc;
                    if (b_last || (cnt_inc == MAX_B)) begin
                        state_d = IDLE;
                        rr_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clock-gate enables: merged mode opens every nibble whenever any nibble is written.
    always_comb begin
        gate = 4'h0;
        if (FORCE_MERGE != 0) begin
            gate = {4{beat_acc && (beat_mask != 4'h0)}};
        end else if (beat_acc) begin
            gate = beat_mask;
        end
        cg_en_d = gate;
    end

    // Bank update: a gated nibble takes new data if masked in, otherwise reloads itself,
    // which keeps out identical between merged and per-nibble modes.
    always_comb begin
        out_d = out_q;
        for (int g = 0; g < 4; g++) begin
            if (gate[g] && beat_mask[g]) begin
                out_d[4*g +: 4] = beat_data[4*g +: 4];
            end else begin
                out_d[4*g +: 4] = out_q[4*g +: 4];
            end
        end
    end

    // State and datapath registers; reset overrides any beat presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= 4'd0;
            out_q   <= 16'h0000;
            cg_en_q <= 4'h0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            cg_en_q <= cg_en_d;
        end
    end

    assign out   = out_q;
    assign cg_en = cg_en_q;
    assign owner = state_q;

    // Ownership is exclusive and the unused encoding never appears.
    a_owner_legal : assert property (@(posedge clk) disable iff (rst) owner != 2'b11);
    a_ready_excl  : assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready));

endmodule

// File: tb/tb_cg_bank_arbiter.sv
// Testbench for cg_bank_arbiter: per-nibble and merged instances driven in lockstep.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: ready/owner compared against hand-computed expectations each cycle.
module tb_cg_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_last, b_valid, b_last;
    logic [3:0]  a_mask, b_mask;
    logic [15:0] a_data, b_data;

    logic        a_ready0, b_ready0, a_ready1, b_ready1;
    logic [15:0] out0, out1;
    logic [3:0]  cg_en0, cg_en1;
    logic [1:0]  owner0, owner1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cg_bank_arbiter #(.FORCE_MERGE(0), .MAX_BURST(8)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_last(a_last), .a_mask(a_mask), .a_data(a_data), .a_ready(a_ready0),
        .b_valid(b_valid), .b_last(b_last), .b_mask(b_mask), .b_data(b_data), .b_ready(b_ready0),
        .out(out0), .cg_en(cg_en0), .owner(owner0)
    );

    cg_bank_arbiter #(.FORCE_MERGE(1), .MAX_BURST(8)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_last(a_last), .a_mask(a_mask), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_last(b_last), .b_mask(b_mask), .b_data(b_data), .b_ready(b_ready1),
        .out(out1), .cg_en(cg_en1), .owner(owner1)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic        al;
        logic [3:0]  am;
        logic [15:0] ad;
        logic        bv;
        logic        bl;
        logic [3:0]  bm;
        logic [15:0] bd;
        logic [15:0] e_out;
        logic [3:0]  e_cg0;
        logic [3:0]  e_cg1;
        logic [1:0]  e_own;
        logic        e_ar;
        logic        e_br;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_mask = 4'h0; a_data = 16'h0;
        b_valid = 1'b0; b_last = 1'b0; b_mask = 4'h0; b_data = 16'h0;
    endtask

    // Ownership and ready of both instances against one expected owner code.
    task automatic chk_own(input string nm, input logic [1:0] e_own);
        chk({nm, "_owner0"}, {14'd0, owner0}, {14'd0, e_own});
        chk({nm, "_owner1"}, {14'd0, owner1}, {14'd0, e_own});
        chk({nm, "_a_ready"}, {15'd0, a_ready0}, {15'd0, e_own == 2'b01});
        chk({nm, "_b_ready"}, {15'd0, b_ready0}, {15'd0, e_own == 2'b10});
    endtask

    // A streams beats with last=0 (one valid gap mid-burst); release after the 8th accepted beat.
    task automatic burst_max(input logic b_at_idle);
        logic [15:0] d;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_valid = 1'b1; a_mask = 4'hF; a_data = 16'h0100;
        step();
        chk_own($sformatf("mb%0d_grant", b_at_idle), 2'b01);
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                a_valid = 1'b0;
                step();
                chk_own($sformatf("mb%0d_gap", b_at_idle), 2'b01);
                a_valid = 1'b1;
            end
            d = 16'h0100 + 16'(k);
            a_data = d;
            step();
            chk($sformatf("mb%0d_out_k%0d", b_at_idle, k), out0, d);
            chk($sformatf("mb%0d_out1_k%0d", b_at_idle, k), out1, d);
            chk_own($sformatf("mb%0d_k%0d", b_at_idle, k), (k < 8) ? 2'b01 : 2'b00);
        end
        b_valid = b_at_idle; b_mask = 4'h1; b_data = 16'h0009;
        a_data = 16'h0109;
        step();
        chk_own($sformatf("mb%0d_regrant", b_at_idle), b_at_idle ? 2'b10 : 2'b01);
        chk($sformatf("mb%0d_idle_out", b_at_idle), out0, 16'h0108);
    endtask

    initial begin
        //           rst  av  al  am    ad        bv  bl  bm    bd        e_out     cg0   cg1   own    ar  br
        vecs[0]  = '{1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,4'h0,16'h0000,16'h0000,4'h0,4'h0,2'b00,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b1,4'hF,16'h1234,1'b1,1'b1,4'hF,16'hABCD,16'h0000,4'h0,4'h0,2'b01,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,4'hF,16'h1234,1'b1,1'b1,4'hF,16'hABCD,16'h1234,4'hF,4'hF,2'b00,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b1,4'hF,16'h1234,1'b1,1'b1,4'hF,16'hABCD,16'h1234,4'h0,4'h0,2'b10,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b1,1'b1,4'hF,16'h1234,1'b1,1'b1,4'h5,16'hFFFF,16'h1F3F,4'h5,4'hF,2'b00,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,4'hF,16'h1234,1'b1,1'b1,4'hF,16'hFFFF,16'h0000,4'h0,4'h0,2'b00,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b0,4'h5,16'hFFFF,16'h0000,4'h0,4'h0,2'b10,1'b0,1'b1};
        vecs[7]  = '{1'b0,1'b1,1'b1,4'hF,16'h5555,1'b1,1'b0,4'h5,16'hFFFF,16'h0F0F,4'h5,4'hF,2'b10,1'b0,1'b1};
        vecs[8]  = '{1'b0,1'b1,1'b1,4'hF,16'h5555,1'b1,1'b0,4'h0,16'h1234,16'h0F0F,4'h0,4'h0,2'b10,1'b0,1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b1,4'hF,16'h5555,1'b0,1'b0,4'h0,16'h0000,16'h0F0F,4'h0,4'h0,2'b10,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b1,1'b1,4'hF,16'h5555,1'b1,1'b1,4'h2,16'h00A0,16'h0FAF,4'h2,4'hF,2'b00,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,4'hF,16'h5555,1'b0,1'b0,4'h0,16'h0000,16'h0FAF,4'h0,4'h0,2'b01,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,4'hF,16'h5555,1'b0,1'b0,4'h0,16'h0000,16'h0FAF,4'h0,4'h0,2'b01,1'b1,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b0,4'h0,16'hFFFF,1'b0,1'b0,4'h0,16'h0000,16'h0FAF,4'h0,4'h0,2'b01,1'b1,1'b0};

        idle_inputs();
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            a_valid = vecs[i].av; a_last = vecs[i].al; a_mask = vecs[i].am; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_last = vecs[i].bl; b_mask = vecs[i].bm; b_data = vecs[i].bd;
            step();
            chk($sformatf("v%0d_out0", i), out0, vecs[i].e_out);
            chk($sformatf("v%0d_out1", i), out1, vecs[i].e_out);
            chk($sformatf("v%0d_cg0", i), {12'd0, cg_en0}, {12'd0, vecs[i].e_cg0});
            chk($sformatf("v%0d_cg1", i), {12'd0, cg_en1}, {12'd0, vecs[i].e_cg1});
            chk($sformatf("v%0d_owner", i), {14'd0, owner0}, {14'd0, vecs[i].e_own});
            chk($sformatf("v%0d_owner1", i), {14'd0, owner1}, {14'd0, vecs[i].e_own});
            chk($sformatf("v%0d_a_ready", i), {15'd0, a_ready0}, {15'd0, vecs[i].e_ar});
            chk($sformatf("v%0d_b_ready", i), {15'd0, b_ready0}, {15'd0, vecs[i].e_br});
            chk($sformatf("v%0d_a_ready1", i), {15'd0, a_ready1}, {15'd0, vecs[i].e_ar});
            chk($sformatf("v%0d_b_ready1", i), {15'd0, b_ready1}, {15'd0, vecs[i].e_br});
        end

        // Forced release at MAX_BURST, then re-grant to A alone or to a waiting B.
        burst_max(1'b0);
        burst_max(1'b1);

        // Reset during the 3rd beat of an A burst; rr must be back to favouring A.
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_valid = 1'b1; a_mask = 4'hF; a_data = 16'h1111;
        b_valid = 1'b1; b_mask = 4'hF; b_data = 16'h7777;
        step();
        chk_own("rs_grant", 2'b01);
        step();
        chk("rs_beat1", out0, 16'h1111);
        a_data = 16'h2222;
        step();
        chk("rs_beat2", out0, 16'h2222);
        a_data = 16'h3333;
        rst = 1'b1;
        step();
        chk("rs_out0", out0, 16'h0000);
        chk("rs_out1", out1, 16'h0000);
        chk("rs_cg0", {12'd0, cg_en0}, 16'h0000);
        chk("rs_cg1", {12'd0, cg_en1}, 16'h0000);
        chk_own("rs_after", 2'b00);
        rst = 1'b0;
        step();
        chk_own("rs_regrant", 2'b01);
        chk("rs_nowrite", out0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cg_bank_arbiter.md
CG_BANK_ARBITER -- requirements
Module: cg_bank_arbiter

Interface
REQ-001 Parameter FORCE_MERGE, default 1: 1 = all four nibble clock-gate enables share one merged enable; 0 = one enable per nibble.
REQ-002 Parameter MAX_BURST, default 8: maximum beats a requester may hold the bank, range 2..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a_valid  input  1  requester A beat valid.
REQ-006 a_last  input  1  requester A final beat of burst.
REQ-007 a_mask  input  4  requester A nibble write mask; bit g covers out[4g+3:4g].
REQ-008 a_data  input  16  requester A write data.
REQ-009 a_ready  output  1  requester A beat accepted when a_valid and a_ready are both 1.
REQ-010 b_valid, b_last, b_mask[3:0], b_data[15:0], b_ready: identical meaning for requester B.
REQ-011 out  output  16  registered register-bank contents.
REQ-012 cg_en  output  4  registered clock-gate enable per nibble group.
REQ-013 owner  output  2  current bank owner: 00 none, 01 A, 10 B; 11 never driven.

Function
REQ-014 FSM states: IDLE, OWN_A, OWN_B; owner SHALL encode the current state.
REQ-015 IDLE: a_ready = b_ready = 0.
REQ-016 IDLE, only A valid: next state OWN_A. Only B valid: next state OWN_B.
REQ-017 IDLE, both valid: grant goes to the requester not served last (rr pointer); rr resets to favour A.
REQ-018 Arbitration latency: exactly one cycle in IDLE before ready asserts.
REQ-019 OWN_A: a_ready = 1, b_ready = 0. OWN_B: mirrored. ready is independent of valid.
REQ-020 Accepted beat: for each group g with mask[g] = 1, out nibble g takes data nibble g on the next edge; other nibbles hold.
REQ-021 Beat counter: clears on grant and increments per accepted beat.
REQ-022 Accepted beat with last = 1, or the MAX_BURST-th accepted beat, ends the burst: next state IDLE and rr points to the other requester.
REQ-023 A forced release at MAX_BURST SHALL behave identically to last = 1; the beat is still written.
REQ-024 FORCE_MERGE = 0: cg_en[g] = 1 in the cycle after an accepted beat with mask[g] = 1; otherwise 0.
REQ-025 FORCE_MERGE = 1: cg_en = 4'hF in the cycle after an accepted beat with a nonzero mask; otherwise 4'h0.
REQ-026 Under FORCE_MERGE = 1, unmasked nibbles reload their own value; out SHALL be bit-identical to FORCE_MERGE = 0 for any stimulus.
REQ-027 A beat with mask = 0 is accepted, counts toward MAX_BURST, changes no out bit and gives cg_en = 0 in both modes.
REQ-028 In OWN_x, a_valid/b_valid from the non-owner is ignored; it waits through IDLE.
REQ-029 Valid low while owning: the state is held and the counter is held.

Reset
REQ-030 With rst = 1 at an edge: out = 16'h0000, cg_en = 4'h0, owner = 00, state IDLE, counter = 0, rr favours A.
REQ-031 Reset mid-burst: the beat in the reset cycle is discarded, and ready is 0 in the cycle after reset.
REQ-032 rst has priority over every other input.

Verification
REQ-033 Both valid after reset, a_data = 16'h1234, a_mask = 4'hF, a_last = 1 -> owner = 01 after 1 cycle; then out = 16'h1234, owner = 00, and B is granted next.
REQ-034 FORCE_MERGE = 0, B beat with mask = 4'b0101, data = 16'hFFFF, out = 16'h0000 -> out = 16'h0F0F and cg_en = 4'b0101.
REQ-035 The same stimulus with FORCE_MERGE = 1 -> out = 16'h0F0F and cg_en = 4'hF; with mask = 0 -> cg_en = 4'h0 and out unchanged.
REQ-036 A holds valid for 10 beats with last = 0 and MAX_BURST = 8 -> release after the 8th beat, IDLE for one cycle, then A is re-granted only if B is not valid.
REQ-037 rst = 1 asserted during the 3rd beat of an A burst -> out = 0, owner = 00 and cg_en = 0 next cycle, with no write from that beat.
